// File: rtl/nibble_add_pkg.sv
// -----------------------------------------------------------------------------
// nibble_add_pkg
// Purpose : shared constants for the nibble-serial adder sequencer.
//   NIBBLE_W : width of one adder step (4 bits)
//   state_t  : sequencer state encoding (IDLE, RUN, DONE)
// Optional feature macro used by the sequencer: SUB_EN (subtraction support).
// -----------------------------------------------------------------------------
package nibble_add_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_adder.sv
// -----------------------------------------------------------------------------
// nibble_adder
// Purpose : purely combinational 4-bit adder with carry in/out; one instance
//           is time-shared by the sequencer across all nibble steps.
// Ports   :
//   a, b  in  NIBBLE_W  nibble operands
//   cin   in  1         carry in
//   s     out NIBBLE_W  nibble sum
//   cout  out 1         carry out
// -----------------------------------------------------------------------------
module nibble_adder
   import nibble_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_add_sequencer.sv
// -----------------------------------------------------------------------------
// nibble_add_sequencer
// Purpose : adds two WIDTH-bit unsigned operands one nibble per clock, LSB
//           first, through a single shared 4-bit adder. An operation takes
//           WIDTH/4 RUN cycles followed by a one-cycle DONE pulse.
// Config  : define SUB_EN to add the 'sub' port (A - B as A + ~B + 1).
// Ports   :
//   clk    in  1        sole clock, rising edge
//   rst    in  1        synchronous active-high reset
//   start  in  1        request; accepted only in IDLE
//   a, b   in  WIDTH    operands, latched when start is accepted
//   sub    in  1        subtract select (only with SUB_EN)
//   busy   out 1        high while in RUN
//   done   out 1        one-cycle pulse while in DONE
//   sum    out WIDTH+1  result, sum[WIDTH] is the final carry-out
// -----------------------------------------------------------------------------
module nibble_add_sequencer
   import nibble_add_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   sum
);

   localparam int N     = WIDTH / NIBBLE_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_width_check
      $error("nibble_add_sequencer: WIDTH must be a multiple of 4 and >= 8");
   end

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH:0]   sum_q;
   logic             busy_q;
   logic             done_q;
   logic             sub_q;

   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_s;
   logic                nib_cout;
   logic                carry_init_d;

`ifdef SUB_EN
   assign carry_init_d = sub;
`else
   assign carry_init_d = 1'b0;
`endif

   // Select the current nibble; B is inverted for subtraction (A + ~B + 1).
   assign nib_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
   assign nib_b = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

   nibble_adder u_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sub_q   <= carry_init_d;
                  idx_q   <= '0;
                  carry_q <= carry_init_d;
                  sum_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] <= nib_s;
               carry_q <= nib_cout;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  sum_q[WIDTH] <= nib_cout;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= DONE;
               end
            end
            DONE: begin
               // Always returns to IDLE; a start seen here is ignored.
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
module tb_nibble_add_sequencer;

   localparam int W = 16;
   localparam int N = W / 4;
`ifdef SUB_EN
   localparam bit SUB_OK = 1'b1;
`else
   localparam bit SUB_OK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W:0]   sum;

   int n_tests  = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   // Count done pulses mid-cycle; a one-cycle pulse is seen exactly once.
   always @(negedge clk) if (done) done_cnt++;

   nibble_add_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum)
   );

   // Reference: plain modular arithmetic on the full operands.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s);
      logic [W-1:0] yy;
      yy = s ? ~y : y;
      return {1'b0, x} + {1'b0, yy} + (W+1)'(s);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
      int cyc;
      int nb;
      int d0;
      logic [W:0] exp;
      sub   = s & SUB_OK;
      exp   = model(aa, bb, sub);
      a     = aa;
      b     = bb;
      start = 1'b1;
      d0    = done_cnt;
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'b0;
      cyc = 0;
      nb  = 0;
      while (!done && cyc < 3*N) begin
         if (busy) nb++;
         tick();
         cyc++;
      end
      chk("latency", 32'(cyc), 32'(N));
      chk("busy_cycles", 32'(nb), 32'(N));
      chk("sum", 32'(sum), 32'(exp));
      tick();
      chk("done_width", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(exp));
      chk("done_count", 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int d0;
      int c;
      int t_done[$];
      logic [W:0] exp39;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      rst = 1'b0;
      tick();

      // Directed adds
      run_op(16'h0003, 16'h0005, 1'b0);
      chk("add_3_5", 32'(sum), 32'h00008);
      run_op(16'h0FFF, 16'h0001, 1'b0);
      chk("carry_chain", 32'(sum), 32'h01000);
      run_op(16'hFFFF, 16'hFFFF, 1'b0);
      chk("max_add", 32'(sum), 32'h1FFFE);

      // start during RUN must be ignored
      a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
      d0 = done_cnt;
      tick();                       // E0: accepted
      start = 1'b0;
      tick();                       // E1
      start = 1'b1; a = 16'hAAAA;
      tick();                       // E2
      tick();                       // E3
      start = 1'b0;
      c = 0;
      while (!done && c < 3*N) begin tick(); c++; end
      chk("ignore_start_sum", 32'(sum), 32'h02345);
      repeat (3) tick();
      chk("ignore_start_done", 32'(done_cnt - d0), 32'd1);
      chk("ignore_start_idle", 32'(busy), 32'd0);

      // Reset mid-RUN
      a = 16'h0003; b = 16'h0004; start = 1'b1;
      d0 = done_cnt;
      tick();                       // E0
      start = 1'b0;
      tick();                       // E1
      rst = 1'b1;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      rst = 1'b0;
      repeat (2*N) tick();
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_op(16'h0008, 16'h0001, 1'b0);
      chk("after_abort", 32'(sum), 32'h00009);

      // Reset has priority over start
      rst = 1'b1; start = 1'b1; a = 16'h0101; b = 16'h0202;
      tick();
      chk("rst_prio_busy", 32'(busy), 32'd0);
      rst = 1'b0; start = 1'b0;
      tick();
      chk("rst_prio_idle", 32'(busy), 32'd0);

      // start held high continuously
      a = 16'h2222; b = 16'h3333; sub = 1'b0; start = 1'b1;
      exp39 = model(16'h2222, 16'h3333, 1'b0);
      for (int i = 0; i < 5*(N+2); i++) begin
         tick();
         if (done) begin
            t_done.push_back(i);
            chk("b2b_sum", 32'(sum), 32'(exp39));
         end
         if (done && busy) chk("b2b_excl", 32'd1, 32'd0);
      end
      start = 1'b0;
      chk("b2b_count", 32'(t_done.size()), 32'd5);
      for (int i = 1; i < t_done.size(); i++)
         chk("b2b_spacing", 32'(t_done[i] - t_done[i-1]), 32'(N+2));
      repeat (N+3) tick();

`ifdef SUB_EN
      run_op(16'h0005, 16'h0003, 1'b1);
      chk("sub_5_3", 32'(sum), 32'h10002);
      run_op(16'h0003, 16'h0005, 1'b1);
      chk("sub_3_5", 32'(sum), 32'h0FFFE);
`endif

      // Randomized operations
      for (int i = 0; i < 25; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nibble_add_sequencer.md
NIBBLE_ADD_SEQUENCER -- requirements
Module: nibble_add_sequencer

Interface
REQ-001 Clocking SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  operand A; sampled on the edge that accepts start.
REQ-007 Port: b  input  WIDTH  operand B; sampled on the edge that accepts start.
REQ-008 Port: sub  input  1  subtract select (A-B); SHALL exist only when SUB_EN is defined.
REQ-009 Port: busy  output  1  high while in RUN.
REQ-010 Port: done  output  1  one-cycle pulse; high while in DONE.
REQ-011 Port: sum  output  WIDTH+1  result; sum[WIDTH] is the final carry-out.

Function
REQ-012 States SHALL be IDLE, RUN and DONE, with N = WIDTH/4 nibbles per operation.
REQ-013 IDLE with start=1 at a rising edge: latch a and b, set nibble index to 0, set carry to 0, clear sum, go to RUN.
REQ-014 IDLE with start=0: remain in IDLE and hold sum.
REQ-015 Each RUN edge processes nibble[idx], LSB first, through the 4-bit adder with the registered carry as carry-in.
REQ-016 On each RUN edge, the sequencer SHALL write sum[4*idx+3:4*idx], register the carry-out and increment idx.
REQ-017 The RUN edge that processes idx=N-1 SHALL write sum[WIDTH] with that nibble's carry-out and go to DONE.
REQ-018 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-019 Latency: with start accepted at edge E0, RUN edges are E1..EN and done is high in the cycle after EN (N=4 for WIDTH=16).
REQ-020 sum SHALL hold its final value from DONE until the next accepted start.
REQ-021 Intermediate sum values during RUN are don't-care to consumers.
REQ-022 start in RUN or DONE SHALL be ignored, with no effect on operands, state or done count.
REQ-023 start=1 in the same cycle DONE is exited is not accepted; start is accepted only on an edge where state is IDLE.
REQ-024 Arithmetic is unsigned modulo 2^(WIDTH+1); no saturation.

Reset
REQ-025 rst=1 at any edge, including mid-RUN or in DONE, SHALL force IDLE.
REQ-026 Reset values: busy=0, done=0, sum=0, idx=0, carry=0, latched operands=0.
REQ-027 An operation aborted by reset SHALL produce no done pulse.
REQ-028 rst takes priority over start in the same cycle.

Configuration
REQ-029 The macro SUB_EN SHALL gate subtraction support.
REQ-030 With SUB_EN defined: sub is latched with start; when sub=1, each B nibble is inverted and the initial carry is 1.
REQ-031 With SUB_EN defined and sub=1, sum SHALL equal A + ~B + 1, so sum[WIDTH]=1 means no borrow.
REQ-032 Without SUB_EN: the sub port is absent, the initial carry is always 0 and operation is add only.

Structure
REQ-033 Shared package nibble_add_pkg SHALL hold NIBBLE_W=4 and the state encoding constants (IDLE, RUN, DONE).
REQ-034 One sub-module nibble_adder (4-bit a, b, cin; 4-bit s, cout; purely combinational) SHALL be instantiated exactly once and shared across all nibble steps.

Verification
REQ-035 Scenario: 0x0003+0x0005 -> sum=0x00008; done high exactly in the cycle after the 4th RUN edge; busy high for 4 cycles.
REQ-036 Scenario: 0x0FFF+0x0001 -> sum=0x01000 (carry crosses three nibble boundaries); 0xFFFF+0xFFFF -> sum=0x1FFFE.
REQ-037 Scenario: start 0x1234+0x1111, then start=1 with a=0xAAAA at the 2nd RUN cycle -> sum=0x02345; exactly one done pulse.
REQ-038 Scenario: rst asserted at the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0 and no done pulse; a following start 0x0008+0x0001 -> sum=0x00009.
REQ-039 Scenario: back-to-back start held high continuously -> operations accepted only from IDLE, one done per operation, spacing N+2 cycles.
REQ-040 Scenario (SUB_EN): 0x0005-0x0003 -> sum=0x10002; 0x0003-0x0005 -> sum=0x0FFFE.
